// File: rtl/tuner_pkg.sv
// tuner_pkg: shared constants and width helpers for the delay arbiter slice
package tuner_pkg;
   localparam int stats_width_c = 16;
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/counter.sv
// counter: wrapping up/down event counter with async active-high reset
module counter #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               up_i,
   input  logic               down_i,
   output logic [width_p-1:0] count_o
);
   // simultaneous up and down cancel out; natural overflow gives the wrap
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) count_o <= '0;
      else if (up_i & ~down_i) count_o <= count_o + width_p'(1);
      else if (down_i & ~up_i) count_o <= count_o - width_p'(1);
endmodule

// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin N:1 arbiter feeding one registered output stage (optional per-requester stats via DELAY_ARBITER_STATS_EN)
module delay_arbiter
   import tuner_pkg::*;
#(
   parameter int width_p   = 8,
   parameter int num_req_p = 4
) (
   input  logic                                 clk_i,
   input  logic                                 reset_i,
   input  logic [num_req_p*width_p-1:0]         data_i,
   input  logic [num_req_p-1:0]                 valid_i,
   output logic [num_req_p-1:0]                 ready_o,
   output logic                                 valid_o,
   output logic [width_p-1:0]                   data_o,
   output logic [id_width(num_req_p)-1:0]       id_o,
`ifdef DELAY_ARBITER_STATS_EN
   output logic [num_req_p*stats_width_c-1:0]   count_o,
`endif
   input  logic                                 ready_i
);
   localparam int id_w_lp = id_width(num_req_p);
   logic [id_w_lp-1:0] last_q, g;
   logic [width_p-1:0] sel;
   logic any, free;
   // pick the valid requester closest after last_q in circular order
   always_comb begin
      int best;
      int d;
      g = '0;
      sel = '0;
      any = 1'b0;
      best = num_req_p;
      d = 0;
      for (int k = 0; k < num_req_p; k++) begin
         d = (k + num_req_p - 1 - int'(last_q)) % num_req_p;
         if (valid_i[k] && d < best) begin
            best = d;
            g = id_w_lp'(k);
            sel = data_i[k*width_p +: width_p];
            any = 1'b1;
         end
      end
   end
   assign free = ~valid_o | ready_i;
   assign ready_o = {{(num_req_p-1){1'b0}}, free & any & ~reset_i} << g;
   // output stage loads on any free cycle; pointer only moves on a real grant
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         valid_o <= 1'b0;
         data_o <= '0;
         id_o <= '0;
         last_q <= id_w_lp'(num_req_p - 1);
      end else if (free) begin
         valid_o <= any;
         if (any) begin
            data_o <= sel;
            id_o <= g;
            last_q <= g;
         end
      end
`ifdef DELAY_ARBITER_STATS_EN
   for (genvar k = 0; k < num_req_p; k++) begin : g_stats
      counter #(.width_p(stats_width_c)) u_cnt (
         .clk_i(clk_i),
         .reset_i(reset_i),
         .up_i(ready_o[k] & valid_i[k]),
         .down_i(1'b0),
         .count_o(count_o[k*stats_width_c +: stats_width_c])
      );
   end
`endif
endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: randomized self-checking bench with a queue-free behavioural model plus directed literal cases
module tb_delay_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N*W-1:0] di = '0;
   logic [N-1:0] vi = '0;
   logic [N-1:0] ro;
   logic vo;
   logic rdy = 1'b0;
   logic [W-1:0] dout;
   logic [1:0] ido;
`ifdef DELAY_ARBITER_STATS_EN
   logic [N*16-1:0] cnt;
`endif
   int errs = 0;
   int checks = 0;
   int mv = 0;
   int md = 0;
   int mid = 0;
   int ptr = N - 1;

   delay_arbiter #(.width_p(W), .num_req_p(N)) dut (
      .clk_i(clk),
      .reset_i(rst),
      .data_i(di),
      .valid_i(vi),
      .ready_o(ro),
      .valid_o(vo),
      .data_o(dout),
      .id_o(ido),
`ifdef DELAY_ARBITER_STATS_EN
      .count_o(cnt),
`endif
      .ready_i(rdy)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int i = 1; i <= N; i++)
         if (((v >> ((p + i) % N)) & 1) != 0) return (p + i) % N;
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // reference: one slot, grant = first valid after the last granted index
   always @(posedge clk or posedge rst) begin
      int g;
      if (rst) begin
         mv = 0; md = 0; mid = 0; ptr = N - 1;
      end else if (mv == 0 || rdy) begin
         g = pick(vi, ptr);
         if (g >= 0) begin
            mv = 1;
            md = int'((di >> (g * W)) & 32'hFF);
            mid = g;
            ptr = g;
         end else mv = 0;
      end
   end

   // compare DUT against the reference every cycle, away from the active edge
   always @(negedge clk) begin
      logic [N-1:0] er;
      int g;
      if (rst) begin
         chk("rst_valid", 32'(vo), 0);
         chk("rst_ready", 32'(ro), 0);
         chk("rst_data", 32'(dout), 0);
         chk("rst_id", 32'(ido), 0);
      end else begin
         g = pick(vi, ptr);
         er = ((mv == 0 || rdy) && g >= 0) ? 4'(1 << g) : '0;
         chk("valid", 32'(vo), mv);
         chk("ready", 32'(ro), 32'(er));
         if (mv != 0) begin
            chk("data", 32'(dout), md);
            chk("id", 32'(ido), mid);
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) nxt();
      @(negedge clk);
      chk("lit_rst_valid", 32'(vo), 0);
      // all requesters active after reset: 0,1,2,3,0
      nxt();
      rst = 1'b0; vi = 4'b1111; rdy = 1'b1; di = 32'h44332211;
      for (int i = 0; i < 5; i++) begin
         nxt();
         if (i == 4) vi = 4'b1001;
         @(negedge clk);
         chk("lit_rot_id", 32'(ido), i % 4);
         chk("lit_rot_valid", 32'(vo), 1);
      end
      // sparse 1001 after last grant 0: 3 then 0
      nxt();
      @(negedge clk);
      chk("lit_sparse_3", 32'(ido), 3);
      nxt();
      vi = 4'b0100; di = 32'h00A50000;
      @(negedge clk);
      chk("lit_sparse_0", 32'(ido), 0);
      // single requester streams with no bubble
      for (int i = 0; i < 5; i++) begin
         nxt();
         @(negedge clk);
         chk("lit_single_data", 32'(dout), 32'hA5);
         chk("lit_single_id", 32'(ido), 2);
         chk("lit_single_valid", 32'(vo), 1);
      end
      vi = 4'b0010; di = 32'h00003C00;
      // backpressure holds the accepted 3C
      nxt();
      rdy = 1'b0; vi = 4'b1111; di = 32'h44330011;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lit_hold_data", 32'(dout), 32'h3C);
         chk("lit_hold_id", 32'(ido), 1);
         chk("lit_hold_ready", 32'(ro), 0);
         if (i < 2) nxt();
      end
      nxt();
      rdy = 1'b1;
      @(negedge clk);
      chk("lit_release_ready", 32'(ro), 32'b0100);
      chk("lit_release_data", 32'(dout), 32'h3C);
      nxt();
      @(negedge clk);
      chk("lit_after_id", 32'(ido), 2);
      chk("lit_after_data", 32'(dout), 32'h33);
      // async reset mid-stream
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("lit_async_valid", 32'(vo), 0);
      chk("lit_async_ready", 32'(ro), 0);
      nxt();
      rst = 1'b0;
      nxt();
      #1;
      chk("lit_post_rst_id", 32'(ido), 0);
      chk("lit_post_rst_valid", 32'(vo), 1);
      // randomized traffic, backpressure and occasional resets
      for (int i = 0; i < 3000; i++) begin
         nxt();
         rst = ($urandom_range(0, 199) == 0);
         vi = ($urandom_range(0, 3) == 0) ? 4'($urandom & $urandom) : 4'($urandom);
         di = $urandom;
         rdy = ($urandom_range(0, 3) != 0);
      end
`ifdef DELAY_ARBITER_STATS_EN
      nxt();
      rst = 1'b1;
      nxt();
      rst = 1'b0; vi = 4'b0001; rdy = 1'b1;
      repeat (70000) @(posedge clk);
      #1 vi = 4'b0000;
      @(negedge clk);
      chk("cnt0", 32'(cnt[15:0]), 4464);
      chk("cnt_rest", 32'(cnt[63:16] != 0), 0);
`endif
      nxt();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
